add_round_sched: RTL and testbench

//  Round-robin scheduler sharing one add counter (now/flag/sum datapath) among NPLAYER requesters.

---
 rtl/add_round_sched.sv | 194 +++++++++++++++++++
 tb/tb_add_round_sched.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_round_sched.sv
// Round-robin scheduler that time-shares one add counter among NPLAYER requesters.
// Optional RUN timeout watchdog enabled by defining ROUND_TIMEOUT_EN.
module add_round_sched #(
    parameter int NPLAYER = 4,
    parameter int ROUNDS  = 4,
    parameter int TIMEOUT = 80
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [NPLAYER-1:0]     req,
    input  logic [6*NPLAYER-1:0]   max_cfg,
    output logic                   add_control,
    output logic                   add_judge,
    output logic [5:0]             add_max,
    input  logic [5:0]             add_now,
    input  logic [9:0]             add_sum,
    output logic [NPLAYER-1:0]     grant,
    output logic                   busy,
    output logic [9:0]             delta,
    output logic                   delta_valid,
    output logic                   done,
    output logic                   err_timeout
);

    localparam int PW = (NPLAYER > 1) ? $clog2(NPLAYER) : 1;
    localparam logic [5:0] ROUNDS_C = 6'(ROUNDS);

    typedef enum logic [1:0] {IDLE, ARB, RUN, DONE} state_t;

    state_t             state, state_n;
    logic [PW-1:0]      rr, rr_n;
    logic [5:0]         cnt, cnt_n;
    logic [9:0]         sum_start, sum_start_n;
    logic               control_n, judge_n, busy_n, dv_n, done_n;
    logic [5:0]         max_n;
    logic [NPLAYER-1:0] grant_n;
    logic [9:0]         delta_n;
    logic [PW:0]        pk;
    logic [PW-1:0]      win;
    logic               pass_end;
    logic               timeout_hit;

    // First requester at or after the pointer, wrapping; returns {found, index}.
    function automatic logic [PW:0] pick(input logic [NPLAYER-1:0] r, input logic [PW-1:0] p);
        logic          found;
        logic [PW-1:0] idx;
        int            k;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NPLAYER; i++) begin
            k = int'(p) + i;
            if (k >= NPLAYER) k = k - NPLAYER;
            if (!found && r[k]) begin
                found = 1'b1;
                idx   = k[PW-1:0];
            end
        end
        return {found, idx};
    endfunction

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] w);
        if (w == PW'(NPLAYER - 1)) return '0;
        return w + 1'b1;
    endfunction

    assign pk       = pick(req, rr);
    assign win      = pk[PW-1:0];
    assign pass_end = (add_now == add_max);

    always_comb begin
        state_n     = state;
        rr_n        = rr;
        cnt_n       = cnt;
        sum_start_n = sum_start;
        control_n   = add_control;
        judge_n     = add_judge;
        max_n       = add_max;
        grant_n     = grant;
        busy_n      = busy;
        delta_n     = delta;
        dv_n        = 1'b0;
        done_n      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n   = ARB;
                    busy_n    = 1'b1;
                    control_n = 1'b1;
                    judge_n   = 1'b0;
                    cnt_n     = '0;
                end
            end
            ARB: begin
                judge_n = 1'b0;
                if (pk[PW]) begin
                    grant_n     = {{(NPLAYER-1){1'b0}}, 1'b1} << win;
                    max_n       = max_cfg[6*int'(win) +: 6];
                    sum_start_n = add_sum;
                    rr_n        = next_ptr(win);
                    judge_n     = 1'b1;
                    state_n     = RUN;
                end
            end
            RUN: begin
                if (pass_end || timeout_hit) begin
                    judge_n = 1'b0;
                    grant_n = '0;
                    cnt_n   = cnt + 1'b1;
                    // A timed-out pass is counted but produces no delta.
                    if (pass_end) begin
                        delta_n = add_sum - sum_start;
                        dv_n    = 1'b1;
                    end
                    if (cnt + 1'b1 == ROUNDS_C) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end else begin
                        state_n = ARB;
                    end
                end
            end
            DONE: begin
                control_n = 1'b0;
                busy_n    = 1'b0;
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr          <= '0;
            cnt         <= '0;
            sum_start   <= '0;
            add_control <= 1'b0;
            add_judge   <= 1'b0;
            add_max     <= '0;
            grant       <= '0;
            busy        <= 1'b0;
            delta       <= '0;
            delta_valid <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            rr          <= rr_n;
            cnt         <= cnt_n;
            sum_start   <= sum_start_n;
            add_control <= control_n;
            add_judge   <= judge_n;
            add_max     <= max_n;
            grant       <= grant_n;
            busy        <= busy_n;
            delta       <= delta_n;
            delta_valid <= dv_n;
            done        <= done_n;
        end
    end

`ifdef ROUND_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tcnt, tcnt_n;
    logic          err_n;

    // tcnt holds the number of RUN cycles already elapsed in this pass.
    assign timeout_hit = (tcnt == TW'(TIMEOUT - 1));

    always_comb begin
        tcnt_n = tcnt;
        err_n  = err_timeout;
        if (state == IDLE && start) err_n = 1'b0;
        if (state == ARB) tcnt_n = '0;
        else if (state == RUN) tcnt_n = tcnt + 1'b1;
        if (state == RUN && timeout_hit && !pass_end) err_n = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tcnt        <= '0;
            err_timeout <= 1'b0;
        end else begin
            tcnt        <= tcnt_n;
            err_timeout <= err_n;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_add_round_sched.sv
// Directed self-checking bench for add_round_sched with a behavioural add counter model.
// Timeout scenario only runs when ROUND_TIMEOUT_EN is defined.
module tb_add_round_sched;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [N-1:0]   req = '0;
    logic [6*N-1:0] max_cfg = '0;
    logic           add_control, add_judge, busy, delta_valid, done, err_timeout;
    logic [5:0]     add_max;
    logic [5:0]     add_now = 6'd0;
    logic [9:0]     add_sum = 10'd0;
    logic [N-1:0]   grant;
    logic [9:0]     delta;
    logic           stub = 1'b0;

    int vecs = 0;
    int errs = 0;

    add_round_sched #(.NPLAYER(N), .ROUNDS(4), .TIMEOUT(80)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .req(req), .max_cfg(max_cfg),
        .add_control(add_control), .add_judge(add_judge), .add_max(add_max),
        .add_now(add_now), .add_sum(add_sum), .grant(grant), .busy(busy),
        .delta(delta), .delta_valid(delta_valid), .done(done), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // Behavioural add block: counts now 0..max, sum gains one per step, wraps without adding.
    always @(posedge clk) begin
        if (!add_control) begin
            add_now <= 6'd0;
            add_sum <= 10'd0;
        end else if (!add_judge) begin
            add_now <= 6'd0;
        end else if (stub) begin
            add_now <= 6'd0;
        end else if (add_now == add_max) begin
            add_now <= 6'd0;
        end else begin
            add_now <= add_now + 6'd1;
            add_sum <= add_sum + 10'd1;
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // Waits for the next delta_valid, counting RUN cycles on the way.
    task automatic run_pass(output logic [N-1:0] g, output int cyc, output logic [9:0] d,
                            output logic dn, output logic [9:0] s, output logic tmo);
        g = '0; cyc = 0; d = '0; dn = 1'b0; s = '0; tmo = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (add_judge) begin
                cyc++;
                g = grant;
            end
            if (delta_valid) begin
                d = delta; dn = done; s = add_sum; tmo = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vecs++;
        if ({add_control, add_judge, add_max, grant, busy, delta, delta_valid, done, err_timeout} !== '0) begin
            errs++;
            $display("FAIL reset_state: got ctl=%b jdg=%b max=%0d grant=%b busy=%b delta=%0d dv=%b done=%b err=%b, want all 0",
                     add_control, add_judge, add_max, grant, busy, delta, delta_valid, done, err_timeout);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_player();
        logic [N-1:0] g; int cyc; logic [9:0] d, s; logic dn, tmo;
        do_reset();
        req = 4'b0001;
        max_cfg = '0;
        max_cfg[5:0] = 6'd5;
        pulse_start();
        vecs++;
        if (!(busy === 1'b1 && add_control === 1'b1 && add_judge === 1'b0)) begin
            errs++;
            $display("FAIL t1_arb_entry: busy=%b ctl=%b jdg=%b, want 1 1 0", busy, add_control, add_judge);
        end
        for (int p = 0; p < 4; p++) begin
            run_pass(g, cyc, d, dn, s, tmo);
            vecs++;
            if (tmo !== 1'b0 || g !== 4'b0001 || cyc != 6 || d !== 10'd5 || dn !== (p == 3)) begin
                errs++;
                $display("FAIL t1_pass%0d: tmo=%b grant=%b cycles=%0d delta=%0d done=%b, want 0 0001 6 5 %b",
                         p, tmo, g, cyc, d, dn, (p == 3));
            end
        end
        vecs++;
        if (s !== 10'd20) begin
            errs++;
            $display("FAIL t1_sum: add_sum=%0d want 20", s);
        end
        @(negedge clk);
        vecs++;
        if (busy !== 1'b0 || add_control !== 1'b0 || done !== 1'b0) begin
            errs++;
            $display("FAIL t1_idle: busy=%b ctl=%b done=%b want 0 0 0", busy, add_control, done);
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] g; int cyc; logic [9:0] d, s; logic dn, tmo;
        logic [N-1:0] eg [4];
        logic [9:0]   ed [4];
        eg[0] = 4'b0001; eg[1] = 4'b0010; eg[2] = 4'b0100; eg[3] = 4'b1000;
        ed[0] = 10'd3;   ed[1] = 10'd1;   ed[2] = 10'd0;   ed[3] = 10'd7;
        do_reset();
        req = 4'b1111;
        max_cfg = {6'd7, 6'd0, 6'd1, 6'd3};
        pulse_start();
        for (int p = 0; p < 4; p++) begin
            run_pass(g, cyc, d, dn, s, tmo);
            vecs++;
            if (tmo !== 1'b0 || g !== eg[p] || d !== ed[p] || cyc != int'(ed[p]) + 1 || dn !== (p == 3)) begin
                errs++;
                $display("FAIL t2_pass%0d: tmo=%b grant=%b delta=%0d cycles=%0d done=%b, want 0 %b %0d %0d %b",
                         p, tmo, g, d, cyc, dn, eg[p], ed[p], int'(ed[p]) + 1, (p == 3));
            end
        end
    endtask

    task automatic test_max_zero();
        logic [N-1:0] g; int cyc; logic [9:0] d, s, s0; logic dn, tmo;
        do_reset();
        req = 4'b0001;
        max_cfg = '0;
        pulse_start();
        s0 = add_sum;
        run_pass(g, cyc, d, dn, s, tmo);
        vecs++;
        if (tmo !== 1'b0 || cyc != 1 || d !== 10'd0 || s !== s0 || g !== 4'b0001) begin
            errs++;
            $display("FAIL t3_zero_pass: tmo=%b cycles=%0d delta=%0d sum=%0d grant=%b, want 0 1 0 %0d 0001",
                     tmo, cyc, d, s, g, s0);
        end
        for (int p = 1; p < 4; p++) run_pass(g, cyc, d, dn, s, tmo);
        vecs++;
        if (tmo !== 1'b0 || dn !== 1'b1) begin
            errs++;
            $display("FAIL t3_done: tmo=%b done=%b want 0 1", tmo, dn);
        end
    endtask

    task automatic test_idle_req();
        logic [N-1:0] g; int cyc; logic [9:0] d, s; logic dn, tmo;
        int bad;
        do_reset();
        req = '0;
        max_cfg = '0;
        pulse_start();
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!(busy === 1'b1 && add_judge === 1'b0 && grant === '0)) bad++;
        end
        vecs++;
        if (bad != 0) begin
            errs++;
            $display("FAIL t4_hold: %0d of 20 cycles had busy/judge/grant wrong, want 0", bad);
        end
        req = 4'b0100;
        max_cfg[17:12] = 6'd3;
        @(negedge clk);
        vecs++;
        if (grant !== 4'b0100 || add_judge !== 1'b1 || add_max !== 6'd3) begin
            errs++;
            $display("FAIL t4_grant: grant=%b jdg=%b max=%0d want 0100 1 3", grant, add_judge, add_max);
        end
        // Withdraw the request and alter the config mid-pass; the pass must still run to 3.
        req = '0;
        max_cfg[17:12] = 6'd9;
        run_pass(g, cyc, d, dn, s, tmo);
        vecs++;
        if (tmo !== 1'b0 || cyc != 3 || d !== 10'd3) begin
            errs++;
            $display("FAIL t4_full_pass: tmo=%b cycles=%0d delta=%0d want 0 3 3", tmo, cyc, d);
        end
        req = 4'b1111;
        @(negedge clk);
        vecs++;
        if (grant !== 4'b1000) begin
            errs++;
            $display("FAIL t4_rr_ptr: grant=%b want 1000", grant);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [N-1:0] g; int cyc, seen, passes; logic [9:0] d, s; logic dn, tmo;
        do_reset();
        req = 4'b0001;
        max_cfg = '0;
        max_cfg[5:0] = 6'd5;
        pulse_start();
        seen = 0;
        for (int i = 0; i < 50 && seen < 3; i++) begin
            @(negedge clk);
            if (add_judge) seen++;
        end
        vecs++;
        if (seen != 3) begin
            errs++;
            $display("FAIL t5_reach_run: RUN cycles seen=%0d want 3", seen);
        end
        rst_n = 1'b0;
        @(negedge clk);
        vecs++;
        if ({add_control, add_judge, add_max, grant, busy, delta, delta_valid, done, err_timeout} !== '0) begin
            errs++;
            $display("FAIL t5_reset_outputs: ctl=%b jdg=%b max=%0d grant=%b busy=%b delta=%0d dv=%b done=%b err=%b, want all 0",
                     add_control, add_judge, add_max, grant, busy, delta, delta_valid, done, err_timeout);
        end
        rst_n = 1'b1;
        pulse_start();
        for (int p = 0; p < 2; p++) run_pass(g, cyc, d, dn, s, tmo);
        // Second start while the session is in ARB must not restart the round count.
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        passes = 0;
        dn = 1'b0;
        for (int p = 0; p < 4 && !dn; p++) begin
            run_pass(g, cyc, d, dn, s, tmo);
            if (!tmo) passes++;
        end
        vecs++;
        if (passes != 2 || dn !== 1'b1 || d !== 10'd5) begin
            errs++;
            $display("FAIL t5_start_ignored: passes=%0d done=%b delta=%0d want 2 1 5", passes, dn, d);
        end
    endtask

`ifdef ROUND_TIMEOUT_EN
    task automatic test_timeout();
        int cyc; logic dv_seen, dropped;
        do_reset();
        stub = 1'b1;
        req = 4'b0001;
        max_cfg = '0;
        max_cfg[5:0] = 6'd5;
        pulse_start();
        cyc = 0; dv_seen = 1'b0; dropped = 1'b0;
        for (int i = 0; i < 200 && !dropped; i++) begin
            @(negedge clk);
            if (delta_valid) dv_seen = 1'b1;
            if (add_judge) cyc++;
            else if (cyc > 0) dropped = 1'b1;
        end
        vecs++;
        if (!dropped || cyc != 80 || err_timeout !== 1'b1 || add_judge !== 1'b0 || dv_seen !== 1'b0) begin
            errs++;
            $display("FAIL t6_timeout: dropped=%b cycles=%0d err=%b jdg=%b dv_seen=%b want 1 80 1 0 0",
                     dropped, cyc, err_timeout, add_judge, dv_seen);
        end
        stub = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single_player();
        test_round_robin();
        test_max_zero();
        test_idle_req();
        test_reset_mid_run();
`ifdef ROUND_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, want normal completion");
        $fatal(1, "watchdog");
    end

endmodule
